ni_flit_injector: RTL
=====================

# ni_flit_injector

Network-interface injection stage sitting directly upstream of a router local input port. It accepts packet words from a core over a valid/ready stream and segments them into router flits: header/tail bits, one-hot VC field and payload. It selects an output VC per packet, tracks per-VC downstream credits, and drives the router's `flit_in`, `flit_in_we` and `credit_out` slice for that port.

## Interface
- `V`, 4, VCs per port (>=1)
- `B`, 4, buffer depth per VC in the router, in flits; initial credit count
- `Fpay`, 32, payload width
- `MIN_PCK_SIZE`, 2, minimum legal packet length in flits (>=1)
- `Fw`, 2+V+Fpay, derived flit width; not overridable

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `in_valid`  in  1  core word valid
- `in_ready`  out  1  injector accepts word this cycle
- `in_data`  in  Fpay  word; the first word of a packet is the header payload (destination etc.)
- `in_last`  in  1  word is the last of its packet
- `flit_out`  out  Fw  flit to router: [Fw-1] hdr, [Fw-2] tail, [Fw-3:Fpay] one-hot VC, [Fpay-1:0] payload
- `flit_out_we`  out  1  flit write strobe
- `credit_in`  in  V  per-VC credit return from router (`credit_out` slice of that port)
- `err_credit_ovf`  out  1  sticky: a credit returned to a VC already at B
- `err_short_pck`  out  1  sticky: a packet was shorter than MIN_PCK_SIZE
- `stat_pck_cnt`  out  32  packets injected
- `stat_flit_cnt`  out  32  flits injected

## Operation
- Per-VC credit counter, width $clog2(B+1), reset to B.
- FSM states: IDLE (waiting for header), BODY (streaming the packet on the locked VC `cur_vc`).
- IDLE: `in_ready` = any VC credit > 0. On `in_valid & in_ready`:
  - `cur_vc` is picked by round-robin among VCs with credit > 0; priority starts one past the last granted VC and resets to VC0.
  - A flit is emitted with hdr=1 and tail=`in_last`.
  - If `in_last` is 0 the FSM goes to BODY, otherwise it stays in IDLE.
- BODY: `in_ready` = credit[cur_vc] > 0. On handshake a flit is emitted with hdr=0 and tail=`in_last`. On `in_last` the FSM returns to IDLE. `cur_vc` is never changed mid-packet.
- Packet length counter: if a tail is accepted with length < MIN_PCK_SIZE, `err_short_pck` is set. The flit is still sent unchanged.
- Credits:
  - A sent flit decrements credit[cur_vc].
  - A `credit_in[i]` bit increments credit[i].
  - If both happen on the same VC in the same cycle, the count is unchanged.
  - An increment at B saturates at B and sets `err_credit_ovf`.
- A VC may carry a new packet as soon as its credit is > 0 (non-atomic reallocation).
- `in_ready` is combinational from state and credits only, never from `in_valid`.

## Timing
- Flit output is registered: a word accepted in cycle n gives `flit_out_we`=1 with its flit in cycle n+1. `flit_out_we` is a single-cycle pulse per flit.
- Throughput is 1 flit/cycle while credit exists. With B=1, one VC, and a router credit round trip R, throughput is 1 flit per R+1 cycles.
- A credit arriving in cycle n is usable for `in_ready` in cycle n+1.
- Reset values:
  - `flit_out`=0, `flit_out_we`=0, both error flags 0, stats 0.
  - FSM=IDLE, all credits=B, RR pointer=VC0.
  - `in_ready`=1 after reset if B>0.
- Reset mid-packet abandons the packet. The router side is expected to be reset together with this block.

## Configuration
- `NI_INJ_STATS_EN`:
  - Defined: `stat_pck_cnt` increments on each tail flit sent, and `stat_flit_cnt` on each flit sent. Both are 32-bit wrap-around counters, reset to 0.
  - Undefined: both ports are tied to 0 and no counter logic is generated.
  - Ports exist in both cases.

## Structure
- Shared package `ni_pkg`: flit field offset constants (HDR_BIT, TAIL_BIT, VC_LSB as functions of V/Fpay) and the FSM state enum {IDLE, BODY}.
- Sub-module `ni_vc_credit_counter` (one instance per VC): inc/dec/saturate, `has_credit` and `ovf` outputs. The round-robin pick stays in the top level.

## Test plan
- Single 3-word packet, V=4, B=4 -> flits on VC0 with hdr/tail pattern 10,00,01 on consecutive cycles; credit[0] ends at 1.
- Five single-word packets, MIN_PCK_SIZE=1 -> hdr=tail=1 each, VCs 0,1,2,3,0. `err_short_pck` stays 0.
- 6-word packet, B=4, no credit return -> 4 flits sent, then `in_ready`=0. Pulse `credit_in[0]` for 2 cycles -> remaining 2 flits sent, the first one cycle after the first credit.
- Send and `credit_in[0]` on VC0 in the same cycle -> credit[0] unchanged. Extra `credit_in[1]` while at B -> `err_credit_ovf`=1 and stays 1.
- 1-word packet with MIN_PCK_SIZE=2 -> flit still sent, `err_short_pck`=1.
- Assert reset mid-BODY -> `flit_out_we` drops immediately, credits=4, next header goes to VC0. With `NI_INJ_STATS_EN`, 3 packets of 2 flits -> stat_pck_cnt=3, stat_flit_cnt=6.

Source files
------------

// File: rtl/ni_pkg.sv
// Shared definitions for the network-interface injection path.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package ni_pkg;

    // Packet framing state of the injector.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } ni_state_e;

    // Flit layout, MSB first: hdr | tail | one-hot VC | payload.
    function automatic int flit_width(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    function automatic int hdr_bit(input int v, input int fpay);
        return fpay + v + 1;
    endfunction

    function automatic int tail_bit(input int v, input int fpay);
        return fpay + v;
    endfunction

    function automatic int vc_lsb(input int fpay);
        return fpay;
    endfunction

endpackage

// File: rtl/ni_vc_credit_counter.sv
// Per-VC downstream credit counter: starts full, -1 per flit sent, +1 per credit returned.
// Latency: a credit or send in cycle n is reflected in has_credit in cycle n+1.
// Backpressure: has_credit low stalls new flits on this VC; returns at full saturate and flag ovf.
module ni_vc_credit_counter
    import ni_pkg::*;
#(
    parameter int B = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic ovf
);

    localparam int CW = (B < 1) ? 1 : $clog2(B + 1);
    localparam logic [CW-1:0] CMAX = CW'(B);

    logic [CW-1:0] count;

    // A send and a return in the same cycle cancel; a lone return at full saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CMAX;
        end else if (inc && !dec) begin
            if (count != CMAX) begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

    assign has_credit = (count != '0);
    assign ovf        = inc & ~dec & (count == CMAX);

endmodule

// File: rtl/ni_flit_injector.sv
// Segments core packet words into router flits, picks a VC per packet round-robin, tracks credits.
// Latency: one cycle, a word accepted in cycle n appears on flit_out with flit_out_we in cycle n+1.
// Backpressure: in_ready drops when no VC (header) or the locked VC (body) has credit.
// Optional NI_INJ_STATS_EN: enables the packet/flit statistics counters (ports tie to 0 otherwise).
module ni_flit_injector
    import ni_pkg::*;
#(
    parameter int V            = 4,
    parameter int B            = 4,
    parameter int Fpay         = 32,
    parameter int MIN_PCK_SIZE = 2,
    localparam int Fw          = 2 + V + Fpay
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Fpay-1:0] in_data,
    input  logic            in_last,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_we,
    input  logic [V-1:0]    credit_in,
    output logic            err_credit_ovf,
    output logic            err_short_pck,
    output logic [31:0]     stat_pck_cnt,
    output logic [31:0]     stat_flit_cnt
);

    localparam int VW       = (V > 1) ? $clog2(V) : 1;
    localparam int LW       = (MIN_PCK_SIZE > 1) ? $clog2(MIN_PCK_SIZE + 1) : 1;
    localparam int HDR_POS  = hdr_bit(V, Fpay);
    localparam int TAIL_POS = tail_bit(V, Fpay);
    localparam int VC_POS   = vc_lsb(Fpay);
    localparam logic [LW-1:0] LEN_SAT = LW'(MIN_PCK_SIZE);

    ni_state_e       state;
    logic [VW-1:0]   cur_vc;
    logic [VW-1:0]   rr_ptr;
    logic [VW-1:0]   pick_idx;
    logic [VW-1:0]   sel_vc;
    logic [LW-1:0]   pck_len;
    logic [V-1:0]    has_credit;
    logic [V-1:0]    ovf_vec;
    logic [V-1:0]    dec_vec;
    logic [V-1:0]    vc_onehot;
    logic [Fw-1:0]   flit_nxt;
    logic            fire;
    logic            short_now;

    // Candidate VC at round-robin offset k from the priority pointer.
    function automatic logic [VW-1:0] rr_cand(input logic [VW-1:0] ptr, input int k);
        int s;
        s = (int'(ptr) + k) % V;
        return VW'(s);
    endfunction

    // One credit counter per VC; sends decrement the VC the flit was written to.
    for (genvar i = 0; i < V; i++) begin : g_vc
        ni_vc_credit_counter #(
            .B(B)
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .inc        (credit_in[i]),
            .dec        (dec_vec[i]),
            .has_credit (has_credit[i]),
            .ovf        (ovf_vec[i])
        );
    end

    // Round-robin pick: scan from the far end so the nearest eligible VC wins.
    always_comb begin
        pick_idx = '0;
        for (int k = V - 1; k >= 0; k--) begin
            if (has_credit[rr_cand(rr_ptr, k)]) begin
                pick_idx = rr_cand(rr_ptr, k);
            end
        end
    end

    // Readiness depends only on state and credits so the core never sees a valid->ready loop.
    always_comb begin
        if (state == IDLE) begin
            in_ready = |has_credit;
        end else begin
            in_ready = has_credit[cur_vc];
        end
    end

    assign fire   = in_valid & in_ready;
    assign sel_vc = (state == IDLE) ? pick_idx : cur_vc;

    // Credit consumption on the VC carrying this flit.
    always_comb begin
        dec_vec = '0;
        if (fire) begin
            dec_vec[sel_vc] = 1'b1;
        end
    end

    // Flit assembly: header flag follows the framing state, tail follows in_last.
    always_comb begin
        vc_onehot                   = V'(1) << sel_vc;
        flit_nxt                    = '0;
        flit_nxt[HDR_POS]           = (state == IDLE);
        flit_nxt[TAIL_POS]          = in_last;
        flit_nxt[VC_POS +: V]       = vc_onehot;
        flit_nxt[Fpay-1:0]          = in_data;
    end

    // Length of the packet including the word being accepted now, compared to the minimum.
    always_comb begin
        if (state == IDLE) begin
            short_now = (MIN_PCK_SIZE > 1);
        end else begin
            short_now = (int'(pck_len) + 1 < MIN_PCK_SIZE);
        end
    end

    // Framing FSM with VC lock, RR pointer, length tracking and the registered flit output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur_vc      <= '0;
            rr_ptr      <= '0;
            pck_len     <= '0;
            flit_out    <= '0;
            flit_out_we <= 1'b0;
        end else begin
            flit_out_we <= fire;
            if (fire) begin
                flit_out <= flit_nxt;
                if (state == IDLE) begin
                    cur_vc  <= pick_idx;
                    rr_ptr  <= (pick_idx == VW'(V - 1)) ? '0 : pick_idx + 1'b1;
                    pck_len <= LW'(1);
                    state   <= in_last ? IDLE : BODY;
                end else begin
                    if (pck_len != LEN_SAT) begin
                        pck_len <= pck_len + 1'b1;
                    end
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

    // Sticky error flags; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_credit_ovf <= 1'b0;
            err_short_pck  <= 1'b0;
        end else begin
            err_credit_ovf <= err_credit_ovf | (|ovf_vec);
            err_short_pck  <= err_short_pck | (fire & in_last & short_now);
        end
    end

`ifdef NI_INJ_STATS_EN
    logic [31:0] pck_cnt_q;
    logic [31:0] flit_cnt_q;

    // Wrap-around counters advanced at acceptance, so they line up with flit_out_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pck_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else if (fire) begin
            flit_cnt_q <= flit_cnt_q + 32'd1;
            if (in_last) begin
                pck_cnt_q <= pck_cnt_q + 32'd1;
            end
        end
    end

    assign stat_pck_cnt  = pck_cnt_q;
    assign stat_flit_cnt = flit_cnt_q;
`else
    assign stat_pck_cnt  = '0;
    assign stat_flit_cnt = '0;
`endif

endmodule
